// File: rtl/core_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_dbg_pkg
//  Description : Shared debug run-control types and constants for the
//                Tachyon core front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_dbg_pkg;

  // Run/halt sequencer states
  typedef enum logic [2:0] {
    RST_WAIT = 3'd0,
    RUN      = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3,
    ITR      = 3'd4,
    RESUME   = 3'd5,
    STEP     = 3'd6
  } run_state_e;

  // Canonical no-op (addi x0, x0, 0) a debugger may inject
  localparam logic [31:0] DBG_ITR_NOP = 32'h00000013;

endpackage
`default_nettype wire

// File: rtl/FetchInflightCnt.sv
`default_nettype none
// ============================================================================
//  Module      : FetchInflightCnt
//  Description : Up/down counter of in-flight fetch requests. Saturates at
//                0 and MAX_OUTSTANDING; illegal overflow/underflow is flagged
//                by an assertion.
//  Revision    : 1.0 - initial release
// ============================================================================
module FetchInflightCnt #(
  parameter int MAX_OUTSTANDING = 4,
  parameter bit ASSERT_EN       = 1'b1,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_i,
  input  logic             return_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             w_overflow;
  logic             w_underflow;

  assign w_overflow  = issue_i && !return_i && (count_q == C_MAX);
  assign w_underflow = return_i && !issue_i && (count_q == '0);

  // Next count: a simultaneous issue and return cancel out; illegal moves hold
  always_comb begin
    count_d = count_q;
    if (issue_i && !return_i && !w_overflow) begin
      count_d = count_q + 1'b1;
    end else if (return_i && !issue_i && !w_underflow) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flag fetch bookkeeping errors from Fetch or memory
  always @(posedge clk) begin
    if (ASSERT_EN && !rst) begin
      assert (!w_overflow)
        else $error("FetchInflightCnt: issue with %0d requests already in flight", count_q);
      assert (!w_underflow)
        else $error("FetchInflightCnt: return with no request in flight");
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : core_run_ctrl
//  Description : Run/halt sequencer. Owns the debug run state and the debug
//                PC, stops/redirects Fetch and injects debugger (ITR)
//                instructions one at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_run_ctrl
  import core_dbg_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int INSN_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter bit ASSERT_EN       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-3:0] rst_addr,
  input  logic                  dbg_on_rst,
  input  logic                  dbg_halt_req,
  input  logic                  dbg_resume_req,
  input  logic                  dbg_step_req,
  input  logic                  dbg_itr_req_valid,
  input  logic [INSN_WIDTH-1:0] dbg_itr_req_insn,
  output logic                  dbg_itr_req_ready,
  input  logic                  dbg_dpc_we,
  input  logic [ADDR_WIDTH-3:0] dbg_dpc_wdata,
  output logic [ADDR_WIDTH-3:0] dpc,
  output logic                  halted,
  output logic                  fetch_stop,
  input  logic                  fetch_issue,
  input  logic                  fetch_return,
  output logic                  itr_valid,
  output logic [INSN_WIDTH-1:0] itr_insn,
  input  logic                  itr_done,
  input  logic                  retire_valid,
  input  logic [ADDR_WIDTH-3:0] retire_next_addr,
  input  logic                  pipe_empty,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-3:0] redirect_addr
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  run_state_e            state_q, state_d;
  logic [ADDR_WIDTH-3:0] dpc_q, dpc_d;
  logic [INSN_WIDTH-1:0] itr_insn_q, itr_insn_d;
  logic                  step_q, step_d;
  logic                  fetch_stop_q, fetch_stop_d;
  logic                  halted_q, halted_d;
  logic                  itr_valid_q, itr_valid_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic                  itr_accept;
  logic [CNT_W-1:0]      outstanding;

  FetchInflightCnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .ASSERT_EN       (ASSERT_EN),
    .CNT_W           (CNT_W)
  ) u_inflight (
    .clk      (clk),
    .rst      (rst),
    .issue_i  (fetch_issue),
    .return_i (fetch_return),
    .count_o  (outstanding)
  );

  // Next-state, dpc tracking and registered-output decode
  always_comb begin
    state_d    = state_q;
    dpc_d      = dpc_q;
    itr_insn_d = itr_insn_q;
    step_d     = step_q;
    itr_accept = 1'b0;
    case (state_q)
      RST_WAIT: begin
        dpc_d   = rst_addr;
        step_d  = 1'b0;
        state_d = dbg_on_rst ? HALTED : RESUME;
      end
      RUN: begin
        if (retire_valid) dpc_d = retire_next_addr;
        if (dbg_halt_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (retire_valid) dpc_d = retire_next_addr;
        if ((outstanding == '0) && pipe_empty) state_d = HALTED;
      end
      HALTED: begin
        if (dbg_dpc_we) dpc_d = dbg_dpc_wdata;
        // ITR wins over step, step wins over resume; losers are dropped
        if (dbg_itr_req_valid) begin
          itr_accept = 1'b1;
          itr_insn_d = dbg_itr_req_insn;
          state_d    = ITR;
        end else if (dbg_step_req) begin
          step_d  = 1'b1;
          state_d = RESUME;
        end else if (dbg_resume_req) begin
          step_d  = 1'b0;
          state_d = RESUME;
        end
      end
      ITR: begin
        if (itr_done) state_d = HALTED;
      end
      RESUME: begin
        state_d = step_q ? STEP : RUN;
      end
      STEP: begin
        if (retire_valid) begin
          dpc_d   = retire_next_addr;
          state_d = DRAIN;
        end
      end
      default: state_d = RST_WAIT;
    endcase

    fetch_stop_d     = !((state_d == RESUME) || (state_d == RUN) || (state_d == STEP));
    halted_d         = (state_d == HALTED) || (state_d == ITR);
    itr_valid_d      = itr_accept;
    redirect_valid_d = (state_d == RESUME);
  end

  // State, dpc and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= RST_WAIT;
      dpc_q            <= '0;
      itr_insn_q       <= '0;
      step_q           <= 1'b0;
      fetch_stop_q     <= 1'b1;
      halted_q         <= 1'b0;
      itr_valid_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      dpc_q            <= dpc_d;
      itr_insn_q       <= itr_insn_d;
      step_q           <= step_d;
      fetch_stop_q     <= fetch_stop_d;
      halted_q         <= halted_d;
      itr_valid_q      <= itr_valid_d;
      redirect_valid_q <= redirect_valid_d;
    end
  end

  // Ready is a decode of the registered HALTED state qualified by the offer
  assign dbg_itr_req_ready = itr_accept;
  assign dpc               = dpc_q;
  assign redirect_addr     = dpc_q;
  assign itr_insn          = itr_insn_q;
  assign halted            = halted_q;
  assign fetch_stop        = fetch_stop_q;
  assign itr_valid         = itr_valid_q;
  assign redirect_valid    = redirect_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_run_ctrl
//  Description : Directed self-checking bench for core_run_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_run_ctrl;
  import core_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] rst_addr;
  logic        dbg_on_rst, dbg_halt_req, dbg_resume_req, dbg_step_req;
  logic        dbg_itr_req_valid;
  logic [31:0] dbg_itr_req_insn;
  logic        dbg_itr_req_ready;
  logic        dbg_dpc_we;
  logic [29:0] dbg_dpc_wdata, dpc;
  logic        halted, fetch_stop, fetch_issue, fetch_return;
  logic        itr_valid;
  logic [31:0] itr_insn;
  logic        itr_done, retire_valid;
  logic [29:0] retire_next_addr;
  logic        pipe_empty, redirect_valid;
  logic [29:0] redirect_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Overflow is exercised on purpose below, so the error assertion is off here
  core_run_ctrl #(
    .ADDR_WIDTH(32), .INSN_WIDTH(32), .MAX_OUTSTANDING(4), .ASSERT_EN(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .rst_addr(rst_addr), .dbg_on_rst(dbg_on_rst),
    .dbg_halt_req(dbg_halt_req), .dbg_resume_req(dbg_resume_req),
    .dbg_step_req(dbg_step_req), .dbg_itr_req_valid(dbg_itr_req_valid),
    .dbg_itr_req_insn(dbg_itr_req_insn), .dbg_itr_req_ready(dbg_itr_req_ready),
    .dbg_dpc_we(dbg_dpc_we), .dbg_dpc_wdata(dbg_dpc_wdata), .dpc(dpc),
    .halted(halted), .fetch_stop(fetch_stop), .fetch_issue(fetch_issue),
    .fetch_return(fetch_return), .itr_valid(itr_valid), .itr_insn(itr_insn),
    .itr_done(itr_done), .retire_valid(retire_valid),
    .retire_next_addr(retire_next_addr), .pipe_empty(pipe_empty),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_addr = 30'h40; dbg_on_rst = 1'b1;
    dbg_halt_req = 0; dbg_resume_req = 0; dbg_step_req = 0;
    dbg_itr_req_valid = 0; dbg_itr_req_insn = '0; dbg_dpc_we = 0; dbg_dpc_wdata = '0;
    fetch_issue = 0; fetch_return = 0; itr_done = 0; retire_valid = 0;
    retire_next_addr = '0; pipe_empty = 0;
    tick(); tick();
    n_checks++; if (fetch_stop !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_stop: got %0b want 1", fetch_stop); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b want 0", halted); end
    n_checks++; if ({redirect_valid, itr_valid, dbg_itr_req_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_valids: got %b want 000", {redirect_valid, itr_valid, dbg_itr_req_ready}); end
    n_checks++; if (dpc !== 30'h0) begin n_fail++; $display("FAIL reset_dpc: got %h want 0", dpc); end
    n_checks++; if (itr_insn !== 32'h0) begin n_fail++; $display("FAIL reset_itr_insn: got %h want 0", itr_insn); end
    rst = 1'b0;
    tick();
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL reset_to_halted: got %0b want 1", halted); end
    n_checks++; if (dpc !== 30'h40) begin n_fail++; $display("FAIL reset_dpc_load: got %h want 40", dpc); end
    n_checks++; if (fetch_stop !== 1'b1) begin n_fail++; $display("FAIL reset_halt_stop: got %0b want 1", fetch_stop); end
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_halt_redirect: got %0b want 0", redirect_valid); end
  endtask

  task automatic test_itr();
    dbg_itr_req_valid = 1; dbg_itr_req_insn = 32'h00100093;
    #1;
    n_checks++; if (dbg_itr_req_ready !== 1'b1) begin n_fail++; $display("FAIL itr_ready: got %0b want 1", dbg_itr_req_ready); end
    tick();
    dbg_itr_req_valid = 0;
    retire_valid = 1; retire_next_addr = 30'h77;
    #1;
    n_checks++; if (itr_valid !== 1'b1) begin n_fail++; $display("FAIL itr_valid: got %0b want 1", itr_valid); end
    n_checks++; if (itr_insn !== 32'h00100093) begin n_fail++; $display("FAIL itr_insn: got %h want 00100093", itr_insn); end
    n_checks++; if (dbg_itr_req_ready !== 1'b0) begin n_fail++; $display("FAIL itr_ready_pulse: got %0b want 0", dbg_itr_req_ready); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL itr_halted: got %0b want 1", halted); end
    tick();
    retire_valid = 0;
    n_checks++; if (itr_valid !== 1'b0) begin n_fail++; $display("FAIL itr_valid_pulse: got %0b want 0", itr_valid); end
    n_checks++; if (dut.state_q !== ITR) begin n_fail++; $display("FAIL itr_wait_state: got %0d want %0d", dut.state_q, ITR); end
    itr_done = 1;
    tick();
    itr_done = 0;
    n_checks++; if (dut.state_q !== HALTED) begin n_fail++; $display("FAIL itr_done_state: got %0d want %0d", dut.state_q, HALTED); end
    n_checks++; if (dpc !== 30'h40) begin n_fail++; $display("FAIL itr_dpc: got %h want 40", dpc); end
  endtask

  task automatic test_itr_vs_resume();
    dbg_itr_req_valid = 1; dbg_itr_req_insn = DBG_ITR_NOP; dbg_resume_req = 1;
    #1;
    n_checks++; if (dbg_itr_req_ready !== 1'b1) begin n_fail++; $display("FAIL prio_ready: got %0b want 1", dbg_itr_req_ready); end
    tick();
    dbg_itr_req_valid = 0; dbg_resume_req = 0;
    n_checks++; if (dut.state_q !== ITR) begin n_fail++; $display("FAIL prio_state: got %0d want %0d", dut.state_q, ITR); end
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL prio_redirect: got %0b want 0", redirect_valid); end
    n_checks++; if (itr_insn !== 32'h00000013) begin n_fail++; $display("FAIL prio_insn: got %h want 00000013", itr_insn); end
    itr_done = 1;
    tick();
    itr_done = 0;
    tick();
    n_checks++; if ({halted, fetch_stop, redirect_valid} !== 3'b110) begin n_fail++; $display("FAIL prio_resume_dropped: got %b want 110", {halted, fetch_stop, redirect_valid}); end
  endtask

  task automatic test_step();
    dbg_dpc_we = 1; dbg_dpc_wdata = 30'h100;
    tick();
    dbg_dpc_we = 0;
    n_checks++; if (dpc !== 30'h100) begin n_fail++; $display("FAIL step_dpc_write: got %h want 100", dpc); end
    dbg_step_req = 1;
    tick();
    dbg_step_req = 0;
    n_checks++; if (redirect_valid !== 1'b1 || redirect_addr !== 30'h100) begin n_fail++; $display("FAIL step_redirect: got %0b/%h want 1/100", redirect_valid, redirect_addr); end
    n_checks++; if (fetch_stop !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL step_run_flags: got stop=%0b halted=%0b want 0/0", fetch_stop, halted); end
    dbg_halt_req = 1;
    tick();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL step_redirect_pulse: got %0b want 0", redirect_valid); end
    tick();
    dbg_halt_req = 0;
    n_checks++; if (dut.state_q !== STEP || fetch_stop !== 1'b0) begin n_fail++; $display("FAIL step_ignores_halt: got state=%0d stop=%0b want %0d/0", dut.state_q, fetch_stop, STEP); end
    retire_valid = 1; retire_next_addr = 30'h101;
    tick();
    retire_valid = 0;
    n_checks++; if (dut.state_q !== DRAIN || fetch_stop !== 1'b1) begin n_fail++; $display("FAIL step_drain: got state=%0d stop=%0b want %0d/1", dut.state_q, fetch_stop, DRAIN); end
    pipe_empty = 1;
    tick();
    pipe_empty = 0;
    n_checks++; if (halted !== 1'b1 || dpc !== 30'h101) begin n_fail++; $display("FAIL step_halted: got halted=%0b dpc=%h want 1/101", halted, dpc); end
  endtask

  task automatic test_halt_drain();
    dbg_resume_req = 1;
    tick();
    dbg_resume_req = 0;
    n_checks++; if (redirect_valid !== 1'b1 || redirect_addr !== 30'h101) begin n_fail++; $display("FAIL drain_redirect: got %0b/%h want 1/101", redirect_valid, redirect_addr); end
    fetch_issue = 1;
    tick();
    n_checks++; if (dut.state_q !== RUN) begin n_fail++; $display("FAIL drain_run_state: got %0d want %0d", dut.state_q, RUN); end
    retire_valid = 1; retire_next_addr = 30'h102;
    tick();
    fetch_issue = 0; retire_next_addr = 30'h103;
    tick();
    dbg_halt_req = 1; retire_next_addr = 30'h104;
    tick();
    dbg_halt_req = 0;
    n_checks++; if (dut.state_q !== DRAIN || fetch_stop !== 1'b1) begin n_fail++; $display("FAIL drain_enter: got state=%0d stop=%0b want %0d/1", dut.state_q, fetch_stop, DRAIN); end
    n_checks++; if (dut.u_inflight.count_o !== 3'd2) begin n_fail++; $display("FAIL drain_outstanding: got %0d want 2", dut.u_inflight.count_o); end
    retire_next_addr = 30'h105; fetch_return = 1;
    tick();
    retire_valid = 0;
    tick();
    fetch_return = 0;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL drain_wait_pipe: got %0b want 0", halted); end
    pipe_empty = 1;
    #1;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL drain_early_halt: got %0b want 0", halted); end
    tick();
    pipe_empty = 0;
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL drain_halted: got %0b want 1", halted); end
    n_checks++; if (dpc !== 30'h105) begin n_fail++; $display("FAIL drain_dpc: got %h want 105", dpc); end
  endtask

  task automatic test_halt_held();
    dbg_halt_req = 1; dbg_resume_req = 1;
    tick();
    dbg_resume_req = 0;
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL held_redirect: got %0b want 1", redirect_valid); end
    tick();
    n_checks++; if (dut.state_q !== RUN || fetch_stop !== 1'b0) begin n_fail++; $display("FAIL held_run: got state=%0d stop=%0b want %0d/0", dut.state_q, fetch_stop, RUN); end
    tick();
    dbg_halt_req = 0;
    n_checks++; if (dut.state_q !== DRAIN || fetch_stop !== 1'b1) begin n_fail++; $display("FAIL held_drain: got state=%0d stop=%0b want %0d/1", dut.state_q, fetch_stop, DRAIN); end
    pipe_empty = 1;
    tick();
    pipe_empty = 0;
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL held_halted: got %0b want 1", halted); end
  endtask

  task automatic test_counter();
    fetch_issue = 1;
    tick(); tick(); tick();
    n_checks++; if (dut.u_inflight.count_o !== 3'd3) begin n_fail++; $display("FAIL cnt_three: got %0d want 3", dut.u_inflight.count_o); end
    fetch_return = 1;
    tick();
    fetch_return = 0;
    n_checks++; if (dut.u_inflight.count_o !== 3'd3) begin n_fail++; $display("FAIL cnt_both: got %0d want 3", dut.u_inflight.count_o); end
    tick();
    n_checks++; if (dut.u_inflight.count_o !== 3'd4) begin n_fail++; $display("FAIL cnt_four: got %0d want 4", dut.u_inflight.count_o); end
    tick();
    fetch_issue = 0;
    n_checks++; if (dut.u_inflight.count_o !== 3'd4) begin n_fail++; $display("FAIL cnt_sat_high: got %0d want 4", dut.u_inflight.count_o); end
    fetch_return = 1;
    for (int i = 0; i < 5; i++) tick();
    fetch_return = 0;
    n_checks++; if (dut.u_inflight.count_o !== 3'd0) begin n_fail++; $display("FAIL cnt_sat_low: got %0d want 0", dut.u_inflight.count_o); end
  endtask

  task automatic test_reset_abort();
    dbg_itr_req_valid = 1; dbg_itr_req_insn = 32'hDEADBEEF;
    tick();
    dbg_itr_req_valid = 0;
    fetch_issue = 1;
    tick();
    fetch_issue = 0;
    rst = 1; dbg_on_rst = 0; rst_addr = 30'h80;
    #1;
    n_checks++; if (dut.state_q !== RST_WAIT || halted !== 1'b0 || fetch_stop !== 1'b1) begin n_fail++; $display("FAIL abort_state: got state=%0d halted=%0b stop=%0b want %0d/0/1", dut.state_q, halted, fetch_stop, RST_WAIT); end
    n_checks++; if (itr_insn !== 32'h0 || dpc !== 30'h0 || dut.u_inflight.count_o !== 3'd0) begin n_fail++; $display("FAIL abort_regs: got insn=%h dpc=%h cnt=%0d want 0/0/0", itr_insn, dpc, dut.u_inflight.count_o); end
    tick();
    rst = 0;
    tick();
    n_checks++; if (redirect_valid !== 1'b1 || redirect_addr !== 30'h80 || fetch_stop !== 1'b0) begin n_fail++; $display("FAIL boot_resume: got %0b/%h stop=%0b want 1/80/0", redirect_valid, redirect_addr, fetch_stop); end
    tick();
    n_checks++; if (dut.state_q !== RUN || redirect_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL boot_run: got state=%0d redirect=%0b halted=%0b want %0d/0/0", dut.state_q, redirect_valid, halted, RUN); end
  endtask

  initial begin
    test_reset();
    test_itr();
    test_itr_vs_resume();
    test_step();
    test_halt_drain();
    test_halt_held();
    test_counter();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run/halt sequencer for the Tachyon core front end. It owns the core debug run state and drives the Fetch stage's stop and halt controls. It injects debugger instructions (ITR) one at a time, and redirects fetch to the debug PC on resume or single-step. It sits between the debug module, Fetch and the backend retire port.

## Interface
- ADDR_WIDTH, 32, byte-address width; all addresses are word addresses [ADDR_WIDTH-1:2]
- INSN_WIDTH, 32, instruction width
- MAX_OUTSTANDING, 4, maximum in-flight fetch requests; counter width is $clog2(MAX_OUTSTANDING+1)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- rst_addr  in  ADDR_WIDTH-2  reset PC; static while rst is high
- dbg_on_rst  in  1  strap: enter HALTED after reset instead of RUN
- dbg_halt_req  in  1  level halt request from the debug module
- dbg_resume_req  in  1  one-cycle resume pulse
- dbg_step_req  in  1  one-cycle single-step pulse
- dbg_itr_req_valid  in  1  ITR offer from the debug module
- dbg_itr_req_insn  in  INSN_WIDTH  ITR instruction
- dbg_itr_req_ready  out  1  ITR accepted this cycle
- dbg_dpc_we  in  1  debugger write of the DPC; honoured only in HALTED
- dbg_dpc_wdata  in  ADDR_WIDTH-2  DPC write data
- dpc  out  ADDR_WIDTH-2  debug PC
- halted  out  1  core is in HALTED or ITR
- fetch_stop  out  1  Fetch must not issue new requests
- fetch_issue  in  1  Fetch issued a request this cycle
- fetch_return  in  1  memory returned a fetch this cycle
- itr_valid  out  1  ITR instruction to Fetch (one-cycle pulse)
- itr_insn  out  INSN_WIDTH  ITR instruction
- itr_done  in  1  backend retired the ITR instruction
- retire_valid  in  1  a program instruction retired
- retire_next_addr  in  ADDR_WIDTH-2  PC following the retired instruction
- pipe_empty  in  1  backend holds no instructions
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_addr  out  ADDR_WIDTH-2  redirect target (= dpc)

## Operation
- States: RST_WAIT, RUN, DRAIN, HALTED, ITR, RESUME, STEP.
- Async reset values:
  - state = RST_WAIT
  - fetch_stop = 1; halted = 0; all valid/ready outputs = 0
  - dpc = 0; itr_insn = 0; outstanding = 0
- RST_WAIT:
  - load dpc <= rst_addr.
  - next state is HALTED if dbg_on_rst, otherwise RESUME (redirect to rst_addr).
- RUN:
  - every retire_valid updates dpc <= retire_next_addr.
  - dbg_halt_req -> DRAIN with fetch_stop = 1.
- DRAIN:
  - fetch_stop stays 1; dpc keeps tracking retires.
  - when outstanding == 0 and pipe_empty -> HALTED.
- HALTED:
  - dbg_dpc_we writes dpc.
  - priority of requests: ITR, then step, then resume.
  - dbg_itr_req_valid: assert ready for one cycle, latch the instruction, -> ITR.
  - dbg_step_req -> RESUME with the step flag set.
  - dbg_resume_req -> RESUME with the step flag clear.
  - requests arriving in any other state are dropped.
- ITR:
  - itr_valid is pulsed on the first cycle only.
  - wait for itr_done, then -> HALTED. Retires in this state do not update dpc.
- RESUME:
  - redirect_valid = 1 with redirect_addr = dpc; fetch_stop = 0.
  - next state is STEP if the step flag is set, otherwise RUN.
- STEP:
  - on the first retire_valid: update dpc, set fetch_stop = 1, -> DRAIN.
  - dbg_halt_req is ignored in STEP.
- Outstanding counter:
  - fetch_issue increments it; fetch_return decrements it; both in the same cycle leaves it unchanged.
  - issue when the count equals MAX_OUTSTANDING, or return when it is 0, is an error: assertion fires and the count saturates.
- A level dbg_halt_req held through RESUME re-enters DRAIN on the first RUN cycle.

## Timing
- All outputs are registered.
- dbg_halt_req high in RUN at edge N: fetch_stop = 1 and state = DRAIN at N+1.
- DRAIN -> HALTED: halted = 1 one cycle after the cycle in which outstanding == 0 and pipe_empty.
- ITR accept at edge N: dbg_itr_req_ready is high in cycle N; itr_valid is high in cycle N+1 only.
- itr_done at N: HALTED at N+1; a new ITR can be accepted at N+1.
- Resume request at N: redirect_valid is high in cycle N+1 only; fetch_stop drops at N+1.
- Reset deasserted: RST_WAIT occupies one cycle, then either HALTED or a one-cycle RESUME.
- rst asserted mid-operation aborts immediately to the reset values; any pending ITR is lost.

## Structure
- Shared package `core_dbg_pkg`:
  - `run_state_e` enum for the seven states
  - `DBG_ITR_NOP` constant (32'h00000013)
- Sub-module `FetchInflightCnt` (parameter MAX_OUTSTANDING): the up/down counter with saturation and the error assertions.
- The FSM and the dpc register live in the top module.

## Test plan
- Reset with dbg_on_rst = 1, rst_addr = 0x40 → halted = 1 at the second edge; dpc = 0x40; fetch_stop = 1.
- Halt in RUN with outstanding = 2:
  - stimulus: pulse two fetch_return cycles, then pipe_empty = 1.
  - response: halted = 1 one cycle after the last condition is met.
  - response: dpc equals the last retire_next_addr seen.
- ITR while HALTED: offer insn 0x00100093 → ready is a one-cycle pulse; itr_valid is a one-cycle pulse carrying 0x00100093; itr_done returns to HALTED; dpc unchanged.
- Step from dpc = 0x100:
  - redirect_valid with addr 0x100.
  - one retire with next_addr = 0x101.
  - response: fetch_stop = 1, DRAIN, then HALTED with dpc = 0x101.
- Simultaneous itr_req_valid and dbg_resume_req in HALTED → ITR is taken and the resume is dropped.
- Simultaneous fetch_issue and fetch_return at count 3 → count stays 3. Issue at count 4 → assertion fires and the count holds at 4.
